bp_piton_mem_arbiter: RTL and testbench
=======================================

BP_PITON_MEM_ARBITER -- requirements
Module: bp_piton_mem_arbiter

Interface
REQ-001 Parameters SHALL be: paddr_width_p, default 40, physical address width; icache_block_width_p, default 256, I-fill width; dcache_block_width_p, default 128, D-fill width; timeout_cycles_p, default 1024, response watchdog limit.
REQ-002 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_i  in  1  synchronous, active-high reset.
REQ-004 ic_req_v_i / ic_req_ready_o  in/out  1/1  I-cache miss request handshake; ic_req_addr_i  in  paddr_width_p  block-aligned fill address.
REQ-005 dc_req_v_i / dc_req_ready_o  in/out  1/1  D-cache request handshake; dc_req_addr_i  in  paddr_width_p; dc_req_wr_i  in  1  writethrough store (1) / fill (0); dc_req_size_i  in  2  log2 bytes; dc_req_data_i  in  64  store data.
REQ-006 mem_req_v_o / mem_req_ready_i  out/in  1/1  downstream request handshake; mem_req_addr_o  out  paddr_width_p; mem_req_wr_o  out  1; mem_req_size_o  out  2; mem_req_data_o  out  64; mem_req_src_o  out  1  0 = I, 1 = D.
REQ-007 mem_resp_v_i  in  1  response strobe; mem_resp_data_i  in  icache_block_width_p  fill data (store acks carry no data).
REQ-008 ic_resp_v_o  out  1; ic_resp_data_o  out  icache_block_width_p; dc_resp_v_o  out  1; dc_resp_data_o  out  dcache_block_width_p  (low bits of mem_resp_data_i).
REQ-009 timeout_err_o  out  1  sticky watchdog error.

Function
REQ-010 FSM SHALL have states e_idle, e_send, e_wait; exactly one request outstanding at any time.
REQ-011 In e_idle, ready_o SHALL be asserted only to the granted requester; on accepted handshake, request fields are latched and FSM goes to e_send next cycle.
REQ-012 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it; last-grant pointer updates only on accepted handshake.
REQ-013 In e_send, mem_req_v_o SHALL be 1 with latched fields held stable until mem_req_ready_i; on handshake go to e_wait.
REQ-014 In e_wait, a mem_resp_v_i SHALL produce a single-cycle ic_resp_v_o or dc_resp_v_o (per latched source) in the same cycle, combinationally, and return FSM to e_idle.
REQ-015 Request-to-downstream latency SHALL be 1 cycle minimum (accept in cycle N, mem_req_v_o in N+1); re-grant SHALL be possible the cycle after the response.
REQ-016 mem_resp_v_i outside e_wait SHALL be ignored (no resp_v_o pulse).
REQ-017 Both ready_o SHALL be 0 in e_send and e_wait.

Reset
REQ-018 reset_i SHALL force e_idle, last-grant = D (so I wins first contention), all latched fields 0, timeout counter 0, timeout_err_o 0.
REQ-019 Reset mid-transaction SHALL abandon the outstanding request; no response pulse is produced for it.
REQ-020 All outputs SHALL be 0 in the cycle following reset assertion, except ic_req_ready_o which follows REQ-011 combinationally.

Configuration
REQ-021 Macro BP_PITON_ARB_TIMEOUT_EN: when defined, a counter SHALL increment each cycle in e_wait, clear on response, and when it reaches timeout_cycles_p set timeout_err_o (sticky until reset) and return FSM to e_idle; when undefined, no counter exists and timeout_err_o SHALL be tied 0.

Structure
REQ-022 FSM state enum and source encoding SHALL live in bp_common_pkg (cache-engine pkgdef); widths derive from the selected bp_proc_param_s.
REQ-023 Arbitration SHALL use a sub-module bsg_arb_round_robin (2 inputs); no other sub-modules.

Verification
REQ-024 I and D valid same cycle after reset -> I granted first (mem_req_src_o=0), D granted after I response.
REQ-025 D store addr 0x80001000, size 3, data 0xDEADBEEF, mem_req_ready_i held 0 for 5 cycles -> mem_req fields stable all 5 cycles, dc_resp_v_o one pulse on ack.
REQ-026 I fill, mem_resp_data_i = 256-bit ramp -> ic_resp_data_o equals ramp, ic_resp_v_o exactly one cycle, dc_resp_v_o 0.
REQ-027 Spurious mem_resp_v_i in e_idle -> no resp_v_o pulse, state unchanged.
REQ-028 reset_i asserted in e_wait, then late response arrives -> no resp pulse, FSM e_idle.
REQ-029 With BP_PITON_ARB_TIMEOUT_EN, timeout_cycles_p=16, no response -> timeout_err_o rises after 16 e_wait cycles, stays 1, next request accepted.

Source files
------------

// File: rtl/bp_common_pkg.sv
// Shared cache-engine definitions for the BlackParrot/OpenPiton memory arbiter.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   bp_arb_state_e  - arbiter FSM state encoding (e_idle, e_send, e_wait)
//   bp_mem_src_e    - request source encoding (0 = I-cache, 1 = D-cache)
//   rr_grant        - two-way round-robin pick, bit 0 = I, bit 1 = D
package bp_common_pkg;

   localparam int unsigned bp_mem_data_width_gp = 64;
   localparam int unsigned bp_mem_size_width_gp = 2;

   typedef enum logic [1:0] {
      e_idle = 2'd0,
      e_send = 2'd1,
      e_wait = 2'd2
   } bp_arb_state_e;

   typedef enum logic {
      e_src_icache = 1'b0,
      e_src_dcache = 1'b1
   } bp_mem_src_e;

   // One-hot grant. On contention the requester that did not win last time
   // gets the grant; a lone requester always wins.
   function automatic logic [1:0] rr_grant(input logic [1:0] reqs,
                                           input bp_mem_src_e last);
      logic [1:0] g;
      g = 2'b00;
      case (reqs)
         2'b01:   g = 2'b01;
         2'b10:   g = 2'b10;
         2'b11:   g = (last == e_src_dcache) ? 2'b01 : 2'b10;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Two-input round-robin arbiter with a registered last-winner pointer.
// Latency: grant is combinational from reqs_i; pointer updates on the clock edge of an accepted grant.
// Backpressure: pointer only advances when yumi_i reports the grant was consumed.
//
// Ports:
//   clk_i, reset_i  - clock, synchronous active-high reset (pointer -> D)
//   reqs_i[1:0]     - request vector, bit 0 = I-cache, bit 1 = D-cache
//   yumi_i          - the current grant was accepted this cycle
//   grants_o[1:0]   - one-hot grant
module bsg_arb_round_robin
   import bp_common_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [1:0] reqs_i,
   input  logic       yumi_i,
   output logic [1:0] grants_o
);

   bp_mem_src_e r_last;
   logic [1:0]  w_grants;

   assign w_grants = rr_grant(reqs_i, r_last);
   assign grants_o = w_grants;

   // Reset to D so that the I-cache wins the first contention.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_last <= e_src_dcache;
      end else if (yumi_i && (|w_grants)) begin
         r_last <= w_grants[1] ? e_src_dcache : e_src_icache;
      end
   end

endmodule

// File: rtl/bp_piton_mem_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/stores onto one downstream memory port, one request in flight.
// Latency: accept in cycle N, mem_req_v_o in N+1; response is routed back combinationally in the cycle it arrives.
// Backpressure: request fields held stable until mem_req_ready_i; both cache ready_o low while a request is outstanding.
//
// Optional feature: define BP_PITON_ARB_TIMEOUT_EN to enable the response watchdog
// (timeout_cycles_p cycles in e_wait sets sticky timeout_err_o and abandons the request).
//
// Ports:
//   clk_i, reset_i                       - clock, synchronous active-high reset
//   ic_req_v_i/ready_o, ic_req_addr_i    - I-cache miss request
//   dc_req_v_i/ready_o, dc_req_addr_i,
//   dc_req_wr_i, dc_req_size_i,
//   dc_req_data_i                        - D-cache fill (wr=0) or writethrough store (wr=1)
//   mem_req_v_o/ready_i, mem_req_*_o     - downstream request, src 0 = I, 1 = D
//   mem_resp_v_i, mem_resp_data_i        - downstream response
//   ic_resp_v_o/data_o, dc_resp_v_o/data_o - routed response, D gets the low bits
//   timeout_err_o                        - sticky watchdog error
module bp_piton_mem_arbiter
   import bp_common_pkg::*;
#(
   parameter int paddr_width_p        = 40,
   parameter int icache_block_width_p = 256,
   parameter int dcache_block_width_p = 128,
   parameter int timeout_cycles_p     = 1024
)
(
   input  logic                              clk_i,
   input  logic                              reset_i,

   input  logic                              ic_req_v_i,
   output logic                              ic_req_ready_o,
   input  logic [paddr_width_p-1:0]          ic_req_addr_i,

   input  logic                              dc_req_v_i,
   output logic                              dc_req_ready_o,
   input  logic [paddr_width_p-1:0]          dc_req_addr_i,
   input  logic                              dc_req_wr_i,
   input  logic [bp_mem_size_width_gp-1:0]   dc_req_size_i,
   input  logic [bp_mem_data_width_gp-1:0]   dc_req_data_i,

   output logic                              mem_req_v_o,
   input  logic                              mem_req_ready_i,
   output logic [paddr_width_p-1:0]          mem_req_addr_o,
   output logic                              mem_req_wr_o,
   output logic [bp_mem_size_width_gp-1:0]   mem_req_size_o,
   output logic [bp_mem_data_width_gp-1:0]   mem_req_data_o,
   output logic                              mem_req_src_o,

   input  logic                              mem_resp_v_i,
   input  logic [icache_block_width_p-1:0]   mem_resp_data_i,

   output logic                              ic_resp_v_o,
   output logic [icache_block_width_p-1:0]   ic_resp_data_o,
   output logic                              dc_resp_v_o,
   output logic [dcache_block_width_p-1:0]   dc_resp_data_o,

   output logic                              timeout_err_o
);

   bp_arb_state_e                      r_state;
   logic [paddr_width_p-1:0]           r_addr;
   logic                               r_wr;
   logic [bp_mem_size_width_gp-1:0]    r_size;
   logic [bp_mem_data_width_gp-1:0]    r_data;
   bp_mem_src_e                        r_src;

   logic [1:0] w_grants;
   logic       w_idle;
   logic       w_ic_fire;
   logic       w_dc_fire;
   logic       w_resp_fire;

   assign w_idle = (r_state == e_idle);

   bsg_arb_round_robin u_rr (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .reqs_i   ({dc_req_v_i, ic_req_v_i}),
      .yumi_i   (w_ic_fire | w_dc_fire),
      .grants_o (w_grants)
   );

   // Grants only exist for valid requesters, so ready never rises for an
   // idle cache; outside e_idle nobody is ready.
   assign ic_req_ready_o = w_idle & w_grants[0];
   assign dc_req_ready_o = w_idle & w_grants[1];
   assign w_ic_fire      = ic_req_v_i & ic_req_ready_o;
   assign w_dc_fire      = dc_req_v_i & dc_req_ready_o;

   assign w_resp_fire    = (r_state == e_wait) & mem_resp_v_i;

`ifdef BP_PITON_ARB_TIMEOUT_EN
   localparam int CntW = $clog2(timeout_cycles_p + 1);
   logic [CntW-1:0] r_to_cnt;
   logic            r_to_err;
   logic            w_to_hit;

   // Counter holds the number of completed e_wait cycles, so the limit is
   // reached at the end of the timeout_cycles_p-th cycle in e_wait.
   assign w_to_hit      = (r_state == e_wait) && !mem_resp_v_i &&
                          (r_to_cnt == CntW'(timeout_cycles_p - 1));
   assign timeout_err_o = r_to_err;
`else
   assign timeout_err_o = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= e_idle;
         r_addr  <= '0;
         r_wr    <= 1'b0;
         r_size  <= '0;
         r_data  <= '0;
         r_src   <= e_src_icache;
`ifdef BP_PITON_ARB_TIMEOUT_EN
         r_to_cnt <= '0;
         r_to_err <= 1'b0;
`endif
      end else begin
         case (r_state)
            e_idle: begin
               // I fills carry no size/data; the source tag marks them as
               // whole-block reads.
               if (w_ic_fire) begin
                  r_addr  <= ic_req_addr_i;
                  r_wr    <= 1'b0;
                  r_size  <= '0;
                  r_data  <= '0;
                  r_src   <= e_src_icache;
                  r_state <= e_send;
               end else if (w_dc_fire) begin
                  r_addr  <= dc_req_addr_i;
                  r_wr    <= dc_req_wr_i;
                  r_size  <= dc_req_size_i;
                  r_data  <= dc_req_data_i;
                  r_src   <= e_src_dcache;
                  r_state <= e_send;
               end
            end
            e_send: begin
               if (mem_req_ready_i) begin
                  r_state <= e_wait;
               end
            end
            e_wait: begin
`ifdef BP_PITON_ARB_TIMEOUT_EN
               if (mem_resp_v_i) begin
                  r_to_cnt <= '0;
                  r_state  <= e_idle;
               end else if (w_to_hit) begin
                  r_to_cnt <= '0;
                  r_to_err <= 1'b1;
                  r_state  <= e_idle;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
`else
               if (mem_resp_v_i) begin
                  r_state <= e_idle;
               end
`endif
            end
            default: r_state <= e_idle;
         endcase
      end
   end

   assign mem_req_v_o    = (r_state == e_send);
   assign mem_req_addr_o = r_addr;
   assign mem_req_wr_o   = r_wr;
   assign mem_req_size_o = r_size;
   assign mem_req_data_o = r_data;
   assign mem_req_src_o  = r_src;

   // Data is zeroed when no response is being delivered so the response
   // buses never show stale or spurious downstream traffic.
   assign ic_resp_v_o    = w_resp_fire & (r_src == e_src_icache);
   assign dc_resp_v_o    = w_resp_fire & (r_src == e_src_dcache);
   assign ic_resp_data_o = ic_resp_v_o ? mem_resp_data_i : '0;
   assign dc_resp_data_o = dc_resp_v_o ? mem_resp_data_i[dcache_block_width_p-1:0] : '0;

endmodule

// File: tb/tb_bp_piton_mem_arbiter.sv
// Directed, table-driven bench for bp_piton_mem_arbiter.
// Inputs change on the falling edge and outputs are compared 2 ns later, well away from the rising edge.
// The watchdog sequence is compiled in only when BP_PITON_ARB_TIMEOUT_EN is defined.
module tb_bp_piton_mem_arbiter;

   localparam int PA = 40;
   localparam int IW = 256;
   localparam int DW = 128;
   localparam int TO = 16;

   localparam logic [PA-1:0] IC_ADDR = 40'h00_0000_1000;
   localparam logic [PA-1:0] DC_ADDR = 40'h00_8000_1000;
   localparam logic [63:0]   DC_DATA = 64'h0000_0000_DEAD_BEEF;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic          reset_i;
   logic          ic_req_v_i, ic_req_ready_o;
   logic [PA-1:0] ic_req_addr_i;
   logic          dc_req_v_i, dc_req_ready_o;
   logic [PA-1:0] dc_req_addr_i;
   logic          dc_req_wr_i;
   logic [1:0]    dc_req_size_i;
   logic [63:0]   dc_req_data_i;
   logic          mem_req_v_o, mem_req_ready_i;
   logic [PA-1:0] mem_req_addr_o;
   logic          mem_req_wr_o;
   logic [1:0]    mem_req_size_o;
   logic [63:0]   mem_req_data_o;
   logic          mem_req_src_o;
   logic          mem_resp_v_i;
   logic [IW-1:0] mem_resp_data_i;
   logic          ic_resp_v_o;
   logic [IW-1:0] ic_resp_data_o;
   logic          dc_resp_v_o;
   logic [DW-1:0] dc_resp_data_o;
   logic          timeout_err_o;

   bp_piton_mem_arbiter #(
      .paddr_width_p        (PA),
      .icache_block_width_p (IW),
      .dcache_block_width_p (DW),
      .timeout_cycles_p     (TO)
   ) dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .ic_req_v_i      (ic_req_v_i),
      .ic_req_ready_o  (ic_req_ready_o),
      .ic_req_addr_i   (ic_req_addr_i),
      .dc_req_v_i      (dc_req_v_i),
      .dc_req_ready_o  (dc_req_ready_o),
      .dc_req_addr_i   (dc_req_addr_i),
      .dc_req_wr_i     (dc_req_wr_i),
      .dc_req_size_i   (dc_req_size_i),
      .dc_req_data_i   (dc_req_data_i),
      .mem_req_v_o     (mem_req_v_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_req_addr_o  (mem_req_addr_o),
      .mem_req_wr_o    (mem_req_wr_o),
      .mem_req_size_o  (mem_req_size_o),
      .mem_req_data_o  (mem_req_data_o),
      .mem_req_src_o   (mem_req_src_o),
      .mem_resp_v_i    (mem_resp_v_i),
      .mem_resp_data_i (mem_resp_data_i),
      .ic_resp_v_o     (ic_resp_v_o),
      .ic_resp_data_o  (ic_resp_data_o),
      .dc_resp_v_o     (dc_resp_v_o),
      .dc_resp_data_o  (dc_resp_data_o),
      .timeout_err_o   (timeout_err_o)
   );

   typedef struct {
      logic rst, icv, dcv, dwr, mrdy, rspv;       // inputs
      logic icr, dcr, mv, msrc, irv, drv;         // expected outputs
   } vec_t;

   localparam int NV = 24;
   vec_t        vecs [NV];
   int          n_vec = 0;
   int          n_bad = 0;
   logic [IW-1:0] ramp;

   function automatic vec_t mk(input logic rst, icv, dcv, dwr, mrdy, rspv,
                               input logic icr, dcr, mv, msrc, irv, drv);
      vec_t v;
      v.rst = rst; v.icv = icv; v.dcv = dcv; v.dwr = dwr; v.mrdy = mrdy; v.rspv = rspv;
      v.icr = icr; v.dcr = dcr; v.mv = mv; v.msrc = msrc; v.irv = irv; v.drv = drv;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic drive(input logic rst, icv, dcv, dwr, mrdy, rspv);
      @(negedge clk_i);
      reset_i         = rst;
      ic_req_v_i      = icv;
      dc_req_v_i      = dcv;
      dc_req_wr_i     = dwr;
      mem_req_ready_i = mrdy;
      mem_resp_v_i    = rspv;
      #2;
      n_vec++;
   endtask

   task automatic apply(input vec_t v, input int idx);
      string p;
      p = $sformatf("v%0d", idx);
      drive(v.rst, v.icv, v.dcv, v.dwr, v.mrdy, v.rspv);
      chk({p, ".ic_ready"}, ic_req_ready_o, v.icr);
      chk({p, ".dc_ready"}, dc_req_ready_o, v.dcr);
      chk({p, ".mem_v"},    mem_req_v_o,    v.mv);
      chk({p, ".ic_resp_v"}, ic_resp_v_o,   v.irv);
      chk({p, ".dc_resp_v"}, dc_resp_v_o,   v.drv);
      chk({p, ".timeout"},  timeout_err_o,  1'b0);
      if (v.mv) begin
         chk({p, ".src"},  mem_req_src_o, v.msrc);
         chk({p, ".addr"}, mem_req_addr_o, v.msrc ? DC_ADDR : IC_ADDR);
         chk({p, ".wr"},   mem_req_wr_o,   v.msrc);
         chk({p, ".size"}, mem_req_size_o, v.msrc ? 2'd3 : 2'd0);
         chk({p, ".data"}, mem_req_data_o, v.msrc ? DC_DATA : 64'd0);
      end
   endtask

   initial begin
      for (int i = 0; i < IW / 8; i++) ramp[i*8 +: 8] = 8'(i);

      //               rst icv dcv dwr mrdy rsp | icr dcr mv src irv drv
      // Contention after reset: I first, D after I's response.
      vecs[0]  = mk(0, 1, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0);
      vecs[1]  = mk(0, 0, 1, 1, 0, 0,  0, 0, 1, 0, 0, 0);
      vecs[2]  = mk(0, 0, 1, 1, 1, 0,  0, 0, 1, 0, 0, 0);
      vecs[3]  = mk(0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
      vecs[4]  = mk(0, 0, 1, 1, 0, 1,  0, 0, 0, 0, 1, 0);
      vecs[5]  = mk(0, 0, 1, 1, 0, 0,  0, 1, 0, 0, 0, 0);
      // D store held by downstream backpressure for 5 cycles.
      vecs[6]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0);
      vecs[7]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0);
      vecs[8]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0);
      vecs[9]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0);
      vecs[10] = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0);
      vecs[11] = mk(0, 0, 0, 0, 1, 0,  0, 0, 1, 1, 0, 0);
      vecs[12] = mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
      // Spurious response while idle is dropped.
      vecs[13] = mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
      // Last winner was D, so I wins this contention; then D wins the next.
      vecs[14] = mk(0, 1, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0);
      vecs[15] = mk(0, 0, 1, 1, 1, 0,  0, 0, 1, 0, 0, 0);
      vecs[16] = mk(0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
      vecs[17] = mk(0, 0, 1, 1, 0, 1,  0, 0, 0, 0, 1, 0);
      vecs[18] = mk(0, 1, 1, 1, 0, 0,  0, 1, 0, 0, 0, 0);
      vecs[19] = mk(0, 1, 0, 0, 1, 0,  0, 0, 1, 1, 0, 0);
      vecs[20] = mk(0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
      // Re-grant the cycle after the response; leave the FSM in e_wait.
      vecs[21] = mk(0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
      vecs[22] = mk(0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 0, 0);
      vecs[23] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

      ic_req_addr_i   = IC_ADDR;
      dc_req_addr_i   = DC_ADDR;
      dc_req_size_i   = 2'd3;
      dc_req_data_i   = DC_DATA;
      mem_resp_data_i = ramp;

      // Reset: second cycle checks the reset state.
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      chk("rst.mem_v",     mem_req_v_o,    1'b0);
      chk("rst.ic_ready",  ic_req_ready_o, 1'b0);
      chk("rst.dc_ready",  dc_req_ready_o, 1'b0);
      chk("rst.ic_resp_v", ic_resp_v_o,    1'b0);
      chk("rst.dc_resp_v", dc_resp_v_o,    1'b0);
      chk("rst.timeout",   timeout_err_o,  1'b0);
      chk("rst.addr",      mem_req_addr_o, '0);
      chk("rst.src",       mem_req_src_o,  1'b0);

      for (int i = 0; i < NV; i++) apply(vecs[i], i);

      // Reset while in e_wait, then a late response arrives.
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1);
      chk("rstw.ic_resp_v", ic_resp_v_o, 1'b0);
      chk("rstw.dc_resp_v", dc_resp_v_o, 1'b0);
      chk("rstw.mem_v",     mem_req_v_o, 1'b0);
      chk("rstw.addr",      mem_req_addr_o, '0);
      drive(0, 1, 0, 0, 0, 0);
      chk("rstw.ic_ready",  ic_req_ready_o, 1'b1);

      // I fill carrying a 256-bit ramp.
      drive(0, 0, 0, 0, 1, 0);
      chk("ramp.mem_v", mem_req_v_o, 1'b1);
      chk("ramp.src",   mem_req_src_o, 1'b0);
      drive(0, 0, 0, 0, 0, 1);
      chk("ramp.ic_resp_v",  ic_resp_v_o, 1'b1);
      chk("ramp.ic_data",    ic_resp_data_o, ramp);
      chk("ramp.dc_resp_v",  dc_resp_v_o, 1'b0);
      drive(0, 0, 0, 0, 0, 0);
      chk("ramp.ic_resp_v_off", ic_resp_v_o, 1'b0);

      // D fill: receives the low 128 bits.
      chk("dfill.dc_ready0", dc_req_ready_o, 1'b0);
      drive(0, 0, 1, 0, 0, 0);
      chk("dfill.dc_ready", dc_req_ready_o, 1'b1);
      drive(0, 0, 0, 0, 1, 0);
      chk("dfill.mem_v", mem_req_v_o, 1'b1);
      chk("dfill.src",   mem_req_src_o, 1'b1);
      chk("dfill.wr",    mem_req_wr_o, 1'b0);
      drive(0, 0, 0, 0, 0, 1);
      chk("dfill.dc_resp_v", dc_resp_v_o, 1'b1);
      chk("dfill.dc_data",   dc_resp_data_o, ramp[DW-1:0]);
      chk("dfill.ic_resp_v", ic_resp_v_o, 1'b0);
      drive(0, 0, 0, 0, 0, 0);
      chk("dfill.dc_resp_v_off", dc_resp_v_o, 1'b0);

`ifdef BP_PITON_ARB_TIMEOUT_EN
      // Watchdog: no response for TO cycles in e_wait.
      drive(0, 1, 0, 0, 0, 0);
      chk("to.ic_ready", ic_req_ready_o, 1'b1);
      drive(0, 0, 0, 0, 1, 0);
      chk("to.mem_v", mem_req_v_o, 1'b1);
      for (int k = 1; k <= TO; k++) begin
         drive(0, 0, 0, 0, 0, 0);
         chk($sformatf("to.err_low%0d", k), timeout_err_o, 1'b0);
         chk($sformatf("to.ic_ready%0d", k), ic_req_ready_o, 1'b0);
      end
      drive(0, 1, 0, 0, 0, 0);
      chk("to.err_set",   timeout_err_o, 1'b1);
      chk("to.reaccept",  ic_req_ready_o, 1'b1);
      drive(0, 0, 0, 0, 0, 0);
      chk("to.err_sticky", timeout_err_o, 1'b1);
      chk("to.mem_v2",     mem_req_v_o, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
